// File: rtl/mat_sched_if.sv
// Request/response handshake bundle for mat_addsub_sched.
// Two requesters present operands with valid/ready; the scheduler returns
// a tagged result on a valid/ready response channel.
interface mat_sched_if #(
  parameter int MAT_W = 64,
  parameter int RES_W = 160
);
  logic             req0_valid;
  logic             req0_ready;
  logic [MAT_W-1:0] req0_mat_A;
  logic [MAT_W-1:0] req0_mat_B;
  logic             req0_sign;

  logic             req1_valid;
  logic             req1_ready;
  logic [MAT_W-1:0] req1_mat_A;
  logic [MAT_W-1:0] req1_mat_B;
  logic             req1_sign;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [RES_W-1:0] resp_mat;
  logic             resp_err;

  modport master (
    output req0_valid, req0_mat_A, req0_mat_B, req0_sign,
    output req1_valid, req1_mat_A, req1_mat_B, req1_sign,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_mat, resp_err
  );

  modport slave (
    input  req0_valid, req0_mat_A, req0_mat_B, req0_sign,
    input  req1_valid, req1_mat_A, req1_mat_B, req1_sign,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_mat, resp_err
  );
endinterface

// File: rtl/mat_addsub_sched.sv
// Scheduler/controller for the 4x4 matrix add/subtract datapath.
// Round-robin arbitration between two requesters, latches the winner's
// operands, clears the path for one cycle, pulses add_en, waits for the
// sticky finish and returns the captured result tagged with the owner ID.
// Optional: define MAT_SCHED_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles; on expiry the response carries resp_err = 1 and
// an all-zero result.
module mat_addsub_sched #(
  parameter int MAT_W          = 64,
  parameter int RES_W          = 160,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  mat_sched_if.slave       bus,
  output logic [MAT_W-1:0] path_mat_A,
  output logic [MAT_W-1:0] path_mat_B,
  output logic             path_sign,
  output logic             path_add_en,
  output logic             path_rst,
  input  logic [RES_W-1:0] path_mat_out,
  input  logic             path_finish
);

  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic             gnt_any;
  logic             gnt_id;
  logic             hs;
  logic [MAT_W-1:0] mat_A_q;
  logic [MAT_W-1:0] mat_B_q;
  logic             sign_q;
  logic             id_q;
  logic [RES_W-1:0] resp_mat_q;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MAT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic             resp_err_q;
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Round-robin grant: the pointer requester wins when valid, else the other
  always_comb begin
    gnt_any = bus.req0_valid | bus.req1_valid;
    gnt_id  = 1'b0;
    if (rr_ptr) gnt_id = bus.req1_valid ? 1'b1 : 1'b0;
    else        gnt_id = bus.req0_valid ? 1'b0 : 1'b1;
  end

  assign hs             = (state == IDLE) & gnt_any;
  assign bus.req0_ready = hs & ~gnt_id;
  assign bus.req1_ready = hs &  gnt_id;

  // Next-state logic for the operation sequence
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (hs) state_nxt = CLR;
      CLR:   state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (path_finish) state_nxt = RESP;
`ifdef MAT_SCHED_TIMEOUT_EN
        else if (timeout) state_nxt = RESP;
`endif
      end
      RESP:  if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Arbitration pointer and owner tag; pointer moves to the loser
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
      id_q   <= 1'b0;
    end else if (hs) begin
      rr_ptr <= ~gnt_id;
      id_q   <= gnt_id;
    end
  end

  // Operand latch at handshake; held through CLR/START/WAIT/RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      mat_A_q <= '0;
      mat_B_q <= '0;
      sign_q  <= 1'b0;
    end else if (hs) begin
      mat_A_q <= gnt_id ? bus.req1_mat_A : bus.req0_mat_A;
      mat_B_q <= gnt_id ? bus.req1_mat_B : bus.req0_mat_B;
      sign_q  <= gnt_id ? bus.req1_sign  : bus.req0_sign;
    end
  end

  // Result capture on finish (or zeroed on timeout when enabled)
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_mat_q <= '0;
`ifdef MAT_SCHED_TIMEOUT_EN
      resp_err_q <= 1'b0;
`endif
    end else if (state == WAIT) begin
      if (path_finish) begin
        resp_mat_q <= path_mat_out;
`ifdef MAT_SCHED_TIMEOUT_EN
        resp_err_q <= 1'b0;
      end else if (timeout) begin
        resp_mat_q <= '0;
        resp_err_q <= 1'b1;
`endif
      end
    end
  end

`ifdef MAT_SCHED_TIMEOUT_EN
  // WAIT cycle counter, held at zero outside WAIT so it starts clean on entry
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 1'b1;
  end
  assign bus.resp_err = resp_err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_mat   = resp_mat_q;

  // Path is held in reset with rst so a stale sticky finish never survives
  assign path_rst    = rst | (state == CLR);
  assign path_add_en = (state == START);
  assign path_mat_A  = mat_A_q;
  assign path_mat_B  = mat_B_q;
  assign path_sign   = sign_q;

endmodule

// File: tb/tb_mat_addsub_sched.sv
// Testbench for mat_addsub_sched: behavioural Add_Path model, randomized
// requesters and consumer, scoreboard of expected responses.
// Define MAT_SCHED_TIMEOUT_EN to exercise the timeout build.
module tb_mat_addsub_sched;
  localparam int MAT_W   = 64;
  localparam int RES_W   = 160;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [MAT_W-1:0] path_mat_A, path_mat_B;
  logic             path_sign, path_add_en, path_rst;
  logic [RES_W-1:0] path_mat_out = '0;
  logic             path_finish  = 1'b0;

  mat_sched_if #(.MAT_W(MAT_W), .RES_W(RES_W)) bus ();

  mat_addsub_sched #(.MAT_W(MAT_W), .RES_W(RES_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .path_mat_A(path_mat_A), .path_mat_B(path_mat_B), .path_sign(path_sign),
    .path_add_en(path_add_en), .path_rst(path_rst),
    .path_mat_out(path_mat_out), .path_finish(path_finish)
  );

  function automatic logic [RES_W-1:0] ref_result(input logic [MAT_W-1:0] a,
                                                  input logic [MAT_W-1:0] b,
                                                  input logic s);
    logic [RES_W-1:0] r;
    logic [9:0] ea, eb;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      ea = {6'b0, a[4*i +: 4]};
      eb = {6'b0, b[4*i +: 4]};
      r[10*i +: 10] = s ? ea - eb : ea + eb;
    end
    return r;
  endfunction

  // Add_Path model: 4 compute cycles after add_en, sticky finish until path_rst
  logic kill = 1'b0;
  logic pbusy = 1'b0;
  int   pcnt = 0;
  always @(posedge clk) begin
    if (path_rst) begin
      path_finish  <= 1'b0;
      path_mat_out <= '0;
      pbusy        <= 1'b0;
      pcnt         <= 0;
    end else if (path_add_en) begin
      pbusy <= 1'b1;
      pcnt  <= 1;
    end else if (pbusy) begin
      if (pcnt == 4) begin
        pbusy <= 1'b0;
        if (!kill) begin
          path_finish  <= 1'b1;
          path_mat_out <= ref_result(path_mat_A, path_mat_B, path_sign);
        end
      end else begin
        pcnt <= pcnt + 1;
      end
    end
  end

  typedef struct {
    logic             id;
    logic [MAT_W-1:0] a;
    logic [MAT_W-1:0] b;
    logic             s;
    logic [RES_W-1:0] mat;
    logic             err;
    int               hs;
    int               lat;
  } exp_t;

  exp_t q[$];

  logic             v[2]      = '{1'b0, 1'b0};
  logic             auto_r[2] = '{1'b0, 1'b0};
  logic [MAT_W-1:0] opA[2]    = '{'0, '0};
  logic [MAT_W-1:0] opB[2]    = '{'0, '0};
  logic             opS[2]    = '{1'b0, 1'b0};
  logic             rr = 1'b1;

  int   n_checks = 0, n_pass = 0;
  int   cyc = 0, last_hs = -100, c_hs = -1;
  logic exp_ptr = 1'b0, prev_valid = 1'b0, prev_taken = 1'b0;
  logic contend = 1'b0, resp_seen = 1'b0;
  logic [RES_W-1:0] hold_mat = '0, last_mat = '0;
  logic hold_id = 1'b0, hold_err = 1'b0, last_id = 1'b0, last_err = 1'b0;

  task automatic chk(input string tag, input logic [RES_W-1:0] got, input logic [RES_W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic new_ops(input int n);
    opA[n] = {$urandom, $urandom};
    opB[n] = {$urandom, $urandom};
    opS[n] = 1'($urandom_range(0, 1));
  endtask

  // One clock cycle: drive, sample mid-cycle, score, advance
  task automatic tick();
    logic busy, taken, g, hv;
    logic [1:0] exp_rdy;
    exp_t e;
    bus.req0_valid = v[0]; bus.req0_mat_A = opA[0]; bus.req0_mat_B = opB[0]; bus.req0_sign = opS[0];
    bus.req1_valid = v[1]; bus.req1_mat_A = opA[1]; bus.req1_mat_B = opB[1]; bus.req1_sign = opS[1];
    bus.resp_ready = rr;
    #1;
    if (rst) begin
      chk("path_rst_in_rst", RES_W'(path_rst), RES_W'(1));
      q.delete();
      exp_ptr = 1'b0; prev_valid = 1'b0; prev_taken = 1'b0;
    end else begin
      busy = (q.size() != 0);
      chk("path_rst", RES_W'(path_rst), RES_W'(cyc == last_hs + 1));
      chk("path_add_en", RES_W'(path_add_en), RES_W'(cyc == last_hs + 2));
      if (busy) begin
        chk("path_mat_A", RES_W'(path_mat_A), RES_W'(q[0].a));
        chk("path_mat_B", RES_W'(path_mat_B), RES_W'(q[0].b));
        chk("path_sign", RES_W'(path_sign), RES_W'(q[0].s));
      end
      taken = 1'b0;
      if (prev_taken) chk("resp_drop", RES_W'(bus.resp_valid), RES_W'(0));
      if (bus.resp_valid === 1'b1) begin
        resp_seen = 1'b1;
        if (!busy) chk("resp_spurious", RES_W'(bus.resp_valid), RES_W'(0));
        else begin
          if (!prev_valid) chk("latency", RES_W'(cyc - q[0].hs), RES_W'(q[0].lat));
          else begin
            chk("hold_mat", bus.resp_mat, hold_mat);
            chk("hold_id", RES_W'(bus.resp_id), RES_W'(hold_id));
            chk("hold_err", RES_W'(bus.resp_err), RES_W'(hold_err));
          end
          hold_mat = bus.resp_mat; hold_id = bus.resp_id; hold_err = bus.resp_err;
          if (rr) begin
            chk("resp_id", RES_W'(bus.resp_id), RES_W'(q[0].id));
            chk("resp_mat", bus.resp_mat, q[0].mat);
            chk("resp_err", RES_W'(bus.resp_err), RES_W'(q[0].err));
            last_mat = bus.resp_mat; last_id = bus.resp_id; last_err = bus.resp_err;
            void'(q.pop_front());
            taken = 1'b1;
          end
        end
      end
      prev_valid = (bus.resp_valid === 1'b1) && !taken;
      prev_taken = taken;
      exp_rdy = 2'b00;
      g = 1'b0;
      hv = !busy && (v[0] || v[1]);
      if (hv) begin
        g = (v[0] && v[1]) ? exp_ptr : v[1];
        exp_rdy = g ? 2'b10 : 2'b01;
      end
      chk("ready", RES_W'({bus.req1_ready, bus.req0_ready}), RES_W'(exp_rdy));
      if (hv) begin
        e.id = g; e.a = opA[g]; e.b = opB[g]; e.s = opS[g];
        e.mat = kill ? '0 : ref_result(opA[g], opB[g], opS[g]);
        e.err = kill; e.hs = cyc; e.lat = kill ? 3 + TIMEOUT : 8;
        q.push_back(e);
        if (contend) begin
          if (c_hs >= 0) chk("hs_spacing", RES_W'(cyc - c_hs), RES_W'(9));
          c_hs = cyc;
        end
        last_hs = cyc;
        exp_ptr = ~g;
        if (auto_r[g]) new_ops(int'(g));
        else v[g] = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    rr = 1'b1;
    while ((q.size() != 0 || v[0] || v[1]) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", RES_W'(n >= bound), RES_W'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    // Reset and reset values
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_resp_valid", RES_W'(bus.resp_valid), RES_W'(0));
    chk("rst_resp_id", RES_W'(bus.resp_id), RES_W'(0));
    chk("rst_resp_mat", bus.resp_mat, RES_W'(0));
    chk("rst_resp_err", RES_W'(bus.resp_err), RES_W'(0));
    chk("rst_path_A", RES_W'(path_mat_A), RES_W'(0));
    chk("rst_path_B", RES_W'(path_mat_B), RES_W'(0));
    chk("rst_path_sign", RES_W'(path_sign), RES_W'(0));

    // Add through requester 0
    v[0] = 1'b1; opA[0] = {16{4'h3}}; opB[0] = {16{4'h2}}; opS[0] = 1'b0;
    drain(40);
    chk("add_mat", last_mat, {16{10'd5}});
    chk("add_id", RES_W'(last_id), RES_W'(0));
    chk("add_err", RES_W'(last_err), RES_W'(0));

    // Subtract through requester 1
    v[1] = 1'b1; opA[1] = {16{4'h7}}; opB[1] = {16{4'h2}}; opS[1] = 1'b1;
    drain(40);
    chk("sub_mat", last_mat, {16{10'd5}});
    chk("sub_id", RES_W'(last_id), RES_W'(1));

    // Contention with both requesters always valid
    auto_r[0] = 1'b1; auto_r[1] = 1'b1;
    new_ops(0); new_ops(1);
    v[0] = 1'b1; v[1] = 1'b1;
    contend = 1'b1; c_hs = -1;
    repeat (40) tick();
    auto_r[0] = 1'b0; auto_r[1] = 1'b0; contend = 1'b0;
    drain(60);

    // Consumer backpressure with a second request pending
    rr = 1'b0;
    new_ops(0); new_ops(1);
    v[0] = 1'b1;
    tick();
    v[1] = 1'b1;
    repeat (28) tick();
    drain(60);

    // Reset during WAIT, then both requesters: req0 must win again
    new_ops(0); v[0] = 1'b1;
    tick();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_resp_valid", RES_W'(bus.resp_valid), RES_W'(0));
    new_ops(0); new_ops(1);
    v[0] = 1'b1; v[1] = 1'b1;
    drain(60);

    // Path never finishes
    kill = 1'b1;
    resp_seen = 1'b0;
    new_ops(1); v[1] = 1'b1;
`ifdef MAT_SCHED_TIMEOUT_EN
    drain(60);
    chk("timeout_err", RES_W'(last_err), RES_W'(1));
    chk("timeout_mat", last_mat, RES_W'(0));
    kill = 1'b0;
`else
    repeat (40) tick();
    chk("no_timeout_resp", RES_W'(resp_seen), RES_W'(0));
    kill = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    // Randomized traffic and consumer stalls
    for (int i = 0; i < 300; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n] && $urandom_range(0, 2) == 0) begin
          new_ops(n);
          v[n] = 1'b1;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
